mem_resp: RTL

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_defs.sv | 21 ++
 rtl/mem_resp_array.sv | 30 +++
 rtl/mem_resp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_defs.sv
// Shared definitions for the mem_resp memory block: data and counter widths,
// init pattern prefix and FSM state encodings.
package mem_defs;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [15:0]      INIT_PREFIX = 16'hA5A5;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Pattern word written to index idx during initialisation.
    function automatic logic [DATA_W-1:0] init_word(input logic [15:0] idx);
        return {INIT_PREFIX, idx};
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_resp: DEPTH x DATA_W, synchronous write,
// combinational (zero-latency) read.
module mem_resp_array
    import mem_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store write data at the rising edge; reads see the old value until then.
    // NOTE: storage has no reset on purpose -- clearing a RAM array would force
    // it into flops; contents are defined only by the init sequence or by writes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_resp.sv
// mem_resp: word-addressed memory with address decode, sticky write-error
// flag, saturating accepted-write counter and an optional power-up
// initialisation sequence.
// Build option: define MEM_RESP_INIT_EN to fill storage with the pattern
// {16'hA5A5, index} after reset before accepting accesses; without it the
// block is ready straight out of reset and contents are undefined until written.
module mem_resp
    import mem_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        err,
    output logic [15:0] wr_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     word_idx;
    logic              addr_ok;
    logic              wr_ok;
    logic              wr_bad;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // An access is legal only when word-aligned and inside the array; any
    // set bit above the array range makes it out of range.
    assign word_idx = addr[AW+1:2];
    assign addr_ok  = (addr[1:0] == 2'b00) && ((addr >> (AW + 2)) == 32'd0);
    assign wr_ok    = wr_en && ready && addr_ok;
    assign wr_bad   = wr_en && ready && !addr_ok;

`ifdef MEM_RESP_INIT_EN
    state_t        state;
    logic [AW-1:0] init_idx;

    // Init FSM: walk every index once, then enter RUN; ready is registered
    // alongside the state so it rises on the edge that writes the last word.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_INIT;
            init_idx <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + AW'(1);
                    if (init_idx == AW'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN:  ;
                default: begin
                    state <= ST_INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Write port mux: the init sequence owns the port until RUN; user writes
    // cannot collide because wr_ok needs ready.
    always_comb begin
        mem_we    = wr_ok;
        mem_waddr = word_idx;
        mem_wdata = data_in;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_idx;
            mem_wdata = init_word(16'(init_idx));
        end
    end
`else
    // No init sequence: accesses are accepted straight out of reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ready <= 1'b1;
        end else begin
            ready <= 1'b1;
        end
    end

    assign mem_we    = wr_ok;
    assign mem_waddr = word_idx;
    assign mem_wdata = data_in;
`endif

    // Sticky error on rejected writes and saturating count of accepted writes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err    <= 1'b0;
            wr_cnt <= '0;
        end else begin
            if (wr_bad) begin
                err <= 1'b1;
            end
            if (wr_ok && (wr_cnt != CNT_MAX)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    mem_resp_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (word_idx),
        .rdata (mem_rdata)
    );

    // Reads are combinational and return zero for any illegal access or
    // while the memory is not ready.
    assign data_out = (ready && addr_ok) ? mem_rdata : 32'h0;

endmodule
